sa_sequencer: RTL and testbench

Front-end sequencer for the 8x8 systolic-array controller. It accepts the operand matrices A and B as a byte stream and drives the controller's command port (EN/WRITE/LOAD/REG_SELECT/IDX/DATA_IN) through four phases: write 128 operands, load 8 columns, compute, and read back 64 results. It returns the results as a 19-bit valid/ready stream. It sits between the bus-facing logic and the controller, and is the only block driving the controller's command inputs.

---
 rtl/sa_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_sa_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_sequencer.sv
// Front-end sequencer for the 8x8 systolic-array controller: streams 128 operand
// bytes into the controller, loads, computes, then reads 64 results back out.
module sa_sequencer #(
    parameter int unsigned COMPUTE_CYCLES = 24
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [18:0] OUT_DATA,
    output logic        OUT_VALID,
    output logic        OUT_LAST,
    input  logic        OUT_READY,
    output logic        BUSY,
    output logic        CTRL_EN,
    output logic        CTRL_WRITE,
    output logic        CTRL_LOAD,
    output logic [3:0]  CTRL_REG_SELECT,
    output logic [2:0]  CTRL_IDX,
    output logic [7:0]  CTRL_DATA_IN,
    input  logic [18:0] CTRL_DATA_OUT,
    input  logic        CTRL_DATA_OUTPUT_EN
);

    typedef enum logic [2:0] {
        WRITE, LOAD, COMPUTE, RD_ISSUE, RD_CAPTURE, RD_WAIT
    } state_e;

    typedef struct packed {
        logic       en;
        logic       wr;
        logic       ld;
        logic [3:0] rs;
        logic [2:0] idx;
        logic [7:0] din;
    } cmd_t;

    state_e      state_q, state_d;
    logic [6:0]  k_q, k_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  n_q, n_d;
    cmd_t        cmd_q, cmd_d;
    logic [18:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        accept;

    function automatic cmd_t read_cmd(input logic [5:0] n);
        read_cmd = '{en: 1'b1, wr: 1'b1, ld: 1'b1, rs: {1'b0, n[5:3]},
                     idx: n[2:0], din: 8'h00};
    endfunction

    assign accept = IN_VALID && (state_q == WRITE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= WRITE;
            k_q         <= '0;
            cnt_q       <= '0;
            n_q         <= '0;
            cmd_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            cmd_q       <= cmd_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // COMPUTE stays one extra cycle so the first read is registered on its exit
    // and appears on the port directly after the last compute command.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        case (state_q)
            WRITE: begin
                if (accept) begin
                    k_d = k_q + 7'd1;
                    if (k_q == 7'd127) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end
                end
            end
            LOAD: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd7) begin
                    state_d = COMPUTE;
                    cnt_d   = '0;
                end
            end
            COMPUTE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(COMPUTE_CYCLES)) begin
                    state_d = RD_ISSUE;
                    cnt_d   = '0;
                    n_d     = '0;
                end
            end
            RD_ISSUE:   state_d = RD_CAPTURE;
            RD_CAPTURE: state_d = RD_WAIT;
            RD_WAIT: begin
                if (OUT_READY) begin
                    if (n_q == 6'd63) begin
                        state_d = WRITE;
                        k_d     = '0;
                        n_d     = '0;
                    end else begin
                        state_d = RD_ISSUE;
                        n_d     = n_q + 6'd1;
                    end
                end
            end
            default: state_d = WRITE;
        endcase
    end

    always_comb begin
        cmd_d       = '0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        case (state_q)
            WRITE: begin
                if (accept) begin
                    cmd_d = '{en: 1'b1, wr: 1'b1, ld: 1'b0, rs: k_q[6:3],
                              idx: k_q[2:0], din: IN_DATA};
                end
            end
            LOAD: cmd_d.en = 1'b1;
            COMPUTE: begin
                if (cnt_q == 8'(COMPUTE_CYCLES)) begin
                    cmd_d = read_cmd(n_d);
                end else begin
                    cmd_d.en = 1'b1;
                end
            end
            RD_CAPTURE: begin
                out_data_d  = CTRL_DATA_OUT;
                out_valid_d = 1'b1;
                out_last_d  = (n_q == 6'd63);
            end
            RD_WAIT: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    if (n_q != 6'd63) begin
                        cmd_d = read_cmd(n_d);
                    end
                end
            end
            default: ;
        endcase
        if (state_q == LOAD) begin
            cmd_d.ld = 1'b1;
        end
    end

    assign IN_READY        = (state_q == WRITE);
    assign BUSY            = !((state_q == WRITE) && (k_q == 7'd0));
    assign OUT_DATA        = out_data_q;
    assign OUT_VALID       = out_valid_q;
    assign OUT_LAST        = out_last_q;
    assign CTRL_EN         = cmd_q.en;
    assign CTRL_WRITE      = cmd_q.wr;
    assign CTRL_LOAD       = cmd_q.ld;
    assign CTRL_REG_SELECT = cmd_q.rs;
    assign CTRL_IDX        = cmd_q.idx;
    assign CTRL_DATA_IN    = cmd_q.din;

    a_capture_valid: assert property (@(posedge CLK) disable iff (RST)
        (state_q == RD_CAPTURE) |-> CTRL_DATA_OUTPUT_EN);

endmodule

// File: tb/tb_sa_sequencer.sv
// Bench for sa_sequencer: a controller stand-in answers reads with A*B from the
// bytes it was written, and a cycle monitor checks the port against a job timeline.
module tb_sa_sequencer;
    localparam int unsigned CC = 24;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  IN_DATA = '0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [18:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_LAST;
    logic        OUT_READY;
    logic        BUSY;
    logic        CTRL_EN, CTRL_WRITE, CTRL_LOAD;
    logic [3:0]  CTRL_REG_SELECT;
    logic [2:0]  CTRL_IDX;
    logic [7:0]  CTRL_DATA_IN;
    logic [18:0] ctrl_dout = '0;
    logic        ctrl_oen = 1'b0;

    sa_sequencer #(.COMPUTE_CYCLES(CC)) dut (
        .CLK(CLK), .RST(RST),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_LAST(OUT_LAST),
        .OUT_READY(OUT_READY), .BUSY(BUSY),
        .CTRL_EN(CTRL_EN), .CTRL_WRITE(CTRL_WRITE), .CTRL_LOAD(CTRL_LOAD),
        .CTRL_REG_SELECT(CTRL_REG_SELECT), .CTRL_IDX(CTRL_IDX),
        .CTRL_DATA_IN(CTRL_DATA_IN), .CTRL_DATA_OUT(ctrl_dout),
        .CTRL_DATA_OUTPUT_EN(ctrl_oen)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Controller stand-in: stores writes, answers a read one cycle later, garbage otherwise.
    logic [7:0] cmem [16][8];

    function automatic logic [18:0] stub_prod(input logic [2:0] c, input logic [2:0] r);
        int s = 0;
        for (int j = 0; j < 8; j++) s += int'(cmem[j][r]) * int'(cmem[8 + int'(c)][j]);
        return 19'(s);
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            ctrl_oen  <= 1'b0;
            ctrl_dout <= '0;
        end else begin
            if (CTRL_EN && CTRL_WRITE && !CTRL_LOAD) cmem[CTRL_REG_SELECT][CTRL_IDX] <= CTRL_DATA_IN;
            if (CTRL_EN && CTRL_WRITE && CTRL_LOAD) begin
                ctrl_dout <= stub_prod(CTRL_REG_SELECT[2:0], CTRL_IDX);
                ctrl_oen  <= 1'b1;
            end else begin
                ctrl_dout <= 19'($urandom);
                ctrl_oen  <= 1'b0;
            end
        end
    end

    // Reference model of one job, derived from the accepted byte stream.
    bit          m_inwrite = 1'b1;
    int          m_k = 0;
    bit          pend_w = 1'b0;
    int          pend_k = 0;
    logic [7:0]  pend_b = '0;
    int          t127 = -1;
    int          read_cyc = -1;
    int          rd_n = 0;
    bit          showing = 1'b0;
    int          jobs_done = 0;
    logic [7:0]  acc_bytes [128];
    logic [18:0] exp_res [64];
    logic [3:0]  wlog_rs [128];
    logic [2:0]  wlog_idx [128];
    logic [7:0]  wlog_d [128];

    function automatic logic [18:0] model_elem(input int n);
        int c = n / 8;
        int r = n % 8;
        int s = 0;
        for (int j = 0; j < 8; j++) s += int'(acc_bytes[j*8 + r]) * int'(acc_bytes[64 + c*8 + j]);
        return 19'(s);
    endfunction

    always @(negedge CLK) begin
        logic [17:0] exp_cmd;
        logic [17:0] act_cmd;
        cyc++;
        act_cmd = {CTRL_EN, CTRL_WRITE, CTRL_LOAD, CTRL_REG_SELECT, CTRL_IDX, CTRL_DATA_IN};
        exp_cmd = '0;
        if (pend_w) begin
            exp_cmd = {3'b110, 4'(pend_k / 8), 3'(pend_k % 8), pend_b};
            wlog_rs[pend_k]  = CTRL_REG_SELECT;
            wlog_idx[pend_k] = CTRL_IDX;
            wlog_d[pend_k]   = CTRL_DATA_IN;
        end else if (t127 >= 0 && cyc > t127 && cyc <= t127 + 8) begin
            exp_cmd = {3'b101, 15'd0};
        end else if (t127 >= 0 && cyc > t127 + 8 && cyc <= t127 + 8 + int'(CC)) begin
            exp_cmd = {3'b100, 15'd0};
        end else if (cyc == read_cyc) begin
            exp_cmd = {3'b111, 4'(rd_n / 8), 3'(rd_n % 8), 8'd0};
        end
        check("ctrl_cmd", 32'(act_cmd), 32'(exp_cmd));
        check("in_ready", 32'(IN_READY), 32'(m_inwrite));
        check("busy", 32'(BUSY), 32'(!(m_inwrite && m_k == 0)));
        check("out_valid", 32'(OUT_VALID), 32'(showing));
        if (showing) begin
            check("out_data", 32'(OUT_DATA), 32'(exp_res[rd_n]));
            check("out_last", 32'(OUT_LAST), 32'(rd_n == 63));
        end
        pend_w = 1'b0;
        if (RST) begin
            m_inwrite = 1'b1; m_k = 0; t127 = -1; read_cyc = -1; rd_n = 0; showing = 1'b0;
        end else begin
            if (m_inwrite && IN_VALID) begin
                acc_bytes[m_k] = IN_DATA;
                pend_w = 1'b1; pend_k = m_k; pend_b = IN_DATA;
                if (m_k == 127) begin
                    m_inwrite = 1'b0;
                    t127 = cyc + 1;
                    read_cyc = cyc + 10 + int'(CC);
                    rd_n = 0;
                    for (int n = 0; n < 64; n++) exp_res[n] = model_elem(n);
                end
                m_k++;
            end
            if (showing && OUT_READY) begin
                showing = 1'b0;
                if (rd_n < 63) begin
                    rd_n++;
                    read_cyc = cyc + 1;
                end else begin
                    m_inwrite = 1'b1; m_k = 0; t127 = -1; read_cyc = -1; rd_n = 0;
                    jobs_done++;
                end
            end else if (read_cyc >= 0 && cyc == read_cyc + 1) begin
                showing = 1'b1;
            end
        end
    end

    // Downstream ready: 0 always-ready, 1 random, 2 one 5-cycle stall on result 10.
    int rdy_mode = 0;
    int stall = 0;
    initial begin
        OUT_READY = 1'b1;
        forever begin
            @(posedge CLK); #1;
            if (rdy_mode == 1) OUT_READY = ($urandom_range(0, 2) != 0);
            else if (rdy_mode == 2 && OUT_VALID && rd_n == 10 && stall < 5) begin
                OUT_READY = 1'b0;
                stall++;
            end else OUT_READY = 1'b1;
        end
    end

    logic [7:0] job_bytes [128];
    logic [7:0] job1_bytes [128];

    task automatic fill_random();
        for (int i = 0; i < 128; i++) job_bytes[i] = 8'($urandom);
    endtask

    task automatic send_job(input bit gapped, input int nbeats);
        int k = 0;
        int guard = 0;
        bit ph = 1'b0;
        bit acc;
        while (k < nbeats && guard < 6000) begin
            if (gapped && ph) IN_VALID = 1'b0;
            else begin
                IN_VALID = 1'b1;
                IN_DATA  = job_bytes[k];
            end
            ph = !ph;
            @(negedge CLK);
            acc = IN_VALID && IN_READY;
            @(posedge CLK); #1;
            if (acc) k++;
            guard++;
        end
        check("send_job_beats", 32'(k), 32'(nbeats));
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 6000 && jobs_done < target; i++) @(negedge CLK);
        check("job_done", 32'(jobs_done), 32'(target));
    endtask

    task automatic do_reset(input int ncyc);
        RST = 1'b1;
        IN_VALID = 1'b0;
        repeat (ncyc) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(IN_READY), 32'd1);
        check({tag, "_out_valid"}, 32'(OUT_VALID), 32'd0);
        check({tag, "_out_last"}, 32'(OUT_LAST), 32'd0);
        check({tag, "_out_data"}, 32'(OUT_DATA), 32'd0);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_ctrl"}, 32'({CTRL_EN, CTRL_WRITE, CTRL_LOAD, CTRL_REG_SELECT,
                                   CTRL_IDX, CTRL_DATA_IN}), 32'd0);
    endtask

    typedef struct {
        int         k;
        logic [3:0] rs;
        logic [2:0] idx;
    } wmap_t;
    wmap_t wmap [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        wmap[0] = '{k: 0,   rs: 4'd0,  idx: 3'd0};
        wmap[1] = '{k: 7,   rs: 4'd0,  idx: 3'd7};
        wmap[2] = '{k: 8,   rs: 4'd1,  idx: 3'd0};
        wmap[3] = '{k: 63,  rs: 4'd7,  idx: 3'd7};
        wmap[4] = '{k: 64,  rs: 4'd8,  idx: 3'd0};
        wmap[5] = '{k: 77,  rs: 4'd9,  idx: 3'd5};
        wmap[6] = '{k: 127, rs: 4'd15, idx: 3'd7};

        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check_reset_vals("rst_init");
        @(posedge CLK); #1;

        // Job 1: gapped input, always-ready output, then the write-mapping table.
        fill_random();
        send_job(1'b1, 128);
        IN_VALID = 1'b0;
        job1_bytes = job_bytes;
        wait_done(1);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("wmap_rs_k%0d", wmap[i].k), 32'(wlog_rs[wmap[i].k]), 32'(wmap[i].rs));
            check($sformatf("wmap_idx_k%0d", wmap[i].k), 32'(wlog_idx[wmap[i].k]), 32'(wmap[i].idx));
            check($sformatf("wmap_data_k%0d", wmap[i].k), 32'(wlog_d[wmap[i].k]), 32'(job1_bytes[wmap[i].k]));
        end

        // Reset mid-stream for two cycles.
        @(posedge CLK); #1;
        fill_random();
        send_job(1'b0, 40);
        do_reset(2);
        @(negedge CLK);
        check_reset_vals("rst_mid");
        @(posedge CLK); #1;

        // Job 2: A = identity, B(i,j) = i+8j, with a stall on result 10; job 3 follows
        // back to back with IN_VALID held high through every phase.
        for (int i = 0; i < 64; i++) job_bytes[i] = 8'(((i / 8) == (i % 8)) ? 1 : 0);
        for (int c = 0; c < 8; c++)
            for (int j = 0; j < 8; j++) job_bytes[64 + c*8 + j] = 8'(j + 8*c);
        stall = 0;
        rdy_mode = 2;
        send_job(1'b0, 128);
        fill_random();
        send_job(1'b0, 128);
        IN_VALID = 1'b0;
        wait_done(3);
        check("stall_applied", 32'(stall), 32'd5);

        // Job 4: reset partway through the compute phase.
        rdy_mode = 1;
        fill_random();
        send_job(1'b0, 128);
        IN_VALID = 1'b0;
        for (int i = 0; i < 200 && cyc < t127 + 18; i++) @(negedge CLK);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        check("rst_compute_ctrl_en", 32'(CTRL_EN), 32'd0);
        check("rst_compute_busy", 32'(BUSY), 32'd0);
        @(posedge CLK); #1;

        // Job 5: fresh job after the aborted one, random back-pressure.
        fill_random();
        send_job(1'b0, 128);
        IN_VALID = 1'b0;
        wait_done(4);

        repeat (3) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
